// File: rtl/connect4_tipos_pkg.sv
// connect4_tipos: shared Connect-4 game types
package connect4_tipos;
    typedef enum logic [1:0] {VACIA, FICHA_1, FICHA_2, FICHA_X} celda_t;
    typedef enum logic [2:0] {
        INICIO, MENU, JUGADOR_INICIAL, TURNO, VERIFICAR, RANDOM, EVALUAR, FIN_JUEGO
    } connect4_turn_state_t;
endpackage

// File: rtl/connect4_turn_timer.sv
// connect4_turn_timer: per-turn down-counter with load, enable and zero flag
module connect4_turn_timer #(
    parameter int TURN_CYCLES = 50_000_000,
    localparam int TW = $clog2(TURN_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    output logic [TW-1:0] count,
    output logic          zero
);
    assign zero = count == '0;
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (load) count <= TW'(TURN_CYCLES - 1);
        else if (en && !zero) count <= count - 1'b1;
endmodule

// File: rtl/connect4_turn_ctrl.sv
// connect4_turn_ctrl: N-player turn sequencer with turn timer, retry limit and draw detection
module connect4_turn_ctrl
    import connect4_tipos::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TURN_CYCLES = 50_000_000,
    parameter int MAX_RETRIES = 3,
    parameter int BOARD_CELLS = 42,
    localparam int PW = $clog2(NUM_PLAYERS),
    localparam int TW = $clog2(TURN_CYCLES),
    localparam int MW = $clog2(BOARD_CELLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio_juego,
    input  logic [PW-1:0]          jugador_inicial,
    input  logic                   t_jugada,
    input  logic                   valido,
    input  logic                   gano,
    input  logic                   random_valido,
    input  logic                   volver_inicio,
    output logic [PW-1:0]          jugador,
    output logic [NUM_PLAYERS-1:0] en_turno,
    output logic                   en_verificar,
    output logic                   en_random,
    output logic [TW-1:0]          tiempo_restante,
    output logic                   fin_juego,
    output logic [PW-1:0]          ganador,
    output logic                   empate
);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    connect4_turn_state_t state;
    logic [MW-1:0] moves;
    logic [RW-1:0] retries;
    logic t_load, t_en, t_zero, last_move;
    assign last_move = moves == MW'(BOARD_CELLS - 1);
    // reload on game start and on every hand-over to the next player
    assign t_load = state == JUGADOR_INICIAL || (state == EVALUAR && !gano && !last_move);
    assign t_en = state == TURNO && !t_jugada;
    connect4_turn_timer #(.TURN_CYCLES(TURN_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(t_load),
        .en(t_en),
        .count(tiempo_restante),
        .zero(t_zero)
    );
    assign en_turno = (state == TURNO) ? NUM_PLAYERS'(1) << jugador : '0;
    assign en_verificar = state == VERIFICAR;
    assign en_random = state == RANDOM;
    assign fin_juego = state == FIN_JUEGO;
    always_ff @(posedge clk)
        if (rst) begin
            state <= INICIO;
            jugador <= '0;
            moves <= '0;
            retries <= '0;
            ganador <= '0;
            empate <= 1'b0;
        end else
            case (state)
                INICIO: begin
                    moves <= '0;
                    retries <= '0;
                    ganador <= '0;
                    empate <= 1'b0;
                    state <= MENU;
                end
                MENU: if (inicio_juego) state <= JUGADOR_INICIAL;
                JUGADOR_INICIAL: begin
                    jugador <= (int'(jugador_inicial) >= NUM_PLAYERS) ? '0 : jugador_inicial;
                    state <= TURNO;
                end
                TURNO:
                    if (t_jugada) state <= VERIFICAR;
                    else if (t_zero) state <= RANDOM;
                VERIFICAR:
                    if (valido) state <= EVALUAR;
                    else begin
                        retries <= retries + 1'b1;
                        state <= (retries == RW'(MAX_RETRIES - 1)) ? RANDOM : TURNO;
                    end
                RANDOM: if (random_valido) state <= EVALUAR;
                EVALUAR: begin
                    moves <= moves + 1'b1;
                    retries <= '0;
                    if (gano) begin
                        ganador <= jugador;
                        state <= FIN_JUEGO;
                    end else if (last_move) begin
                        empate <= 1'b1;
                        state <= FIN_JUEGO;
                    end else begin
                        jugador <= (jugador == PW'(NUM_PLAYERS - 1)) ? '0 : jugador + 1'b1;
                        state <= TURNO;
                    end
                end
                FIN_JUEGO: if (volver_inicio) state <= INICIO;
                default: state <= INICIO;
            endcase
endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// tb_connect4_turn_ctrl: table vectors, directed corner cases and a random run against a game model
module tb_connect4_turn_ctrl;
    typedef struct packed {
        logic rst, ini;
        logic [1:0] jini;
        logic tj, val, gano, rv, volv;
    } in_t;
    typedef struct packed {
        logic [1:0] jug;
        logic [3:0] et;
        logic ev, er;
        logic [2:0] t;
        logic fin;
        logic [1:0] gan;
        logic emp;
    } out_t;
    typedef struct {in_t i; out_t o;} row_t;
    typedef enum {M_START, M_MENU, M_PICK, M_TURN, M_CHECK, M_RAND, M_SCORE, M_OVER} mph_t;

    localparam in_t IDLE = 9'h000, RST = 9'h100, INI = 9'h080, J1 = 9'h020, J3 = 9'h060;
    localparam in_t TJ = 9'h010, VAL = 9'h008, GANO = 9'h004, RV = 9'h002, VOLV = 9'h001;

    logic clk = 1'b0;
    logic rst, inicio_juego, t_jugada, valido, gano, random_valido, volver_inicio;
    logic [1:0] jini;
    logic [0:0] a_jug, a_gan;
    logic [1:0] a_et;
    logic [2:0] a_t;
    logic a_ev, a_er, a_fin, a_emp;
    logic [1:0] b_jug, b_gan;
    logic [3:0] b_et;
    logic [2:0] b_t;
    logic b_ev, b_er, b_fin, b_emp;
    logic [1:0] c_jug, c_gan, c_t;
    logic [2:0] c_et;
    logic c_ev, c_er, c_fin, c_emp;
    out_t act;
    int sel = 0;
    int errors = 0, checks = 0;
    int np, tc, mr, bc;
    mph_t ph;
    int cur, left, miss, placed, win;
    bit draw;
    row_t tab[$];

    always #5 clk = ~clk;

    connect4_turn_ctrl #(.NUM_PLAYERS(2), .TURN_CYCLES(8), .MAX_RETRIES(3), .BOARD_CELLS(4)) dut_a (
        .clk(clk), .rst(rst), .inicio_juego(inicio_juego), .jugador_inicial(jini[0:0]),
        .t_jugada(t_jugada), .valido(valido), .gano(gano), .random_valido(random_valido),
        .volver_inicio(volver_inicio), .jugador(a_jug), .en_turno(a_et), .en_verificar(a_ev),
        .en_random(a_er), .tiempo_restante(a_t), .fin_juego(a_fin), .ganador(a_gan), .empate(a_emp));
    connect4_turn_ctrl #(.NUM_PLAYERS(4), .TURN_CYCLES(6), .MAX_RETRIES(2), .BOARD_CELLS(10)) dut_b (
        .clk(clk), .rst(rst), .inicio_juego(inicio_juego), .jugador_inicial(jini),
        .t_jugada(t_jugada), .valido(valido), .gano(gano), .random_valido(random_valido),
        .volver_inicio(volver_inicio), .jugador(b_jug), .en_turno(b_et), .en_verificar(b_ev),
        .en_random(b_er), .tiempo_restante(b_t), .fin_juego(b_fin), .ganador(b_gan), .empate(b_emp));
    connect4_turn_ctrl #(.NUM_PLAYERS(3), .TURN_CYCLES(4), .MAX_RETRIES(1), .BOARD_CELLS(42)) dut_c (
        .clk(clk), .rst(rst), .inicio_juego(inicio_juego), .jugador_inicial(jini),
        .t_jugada(t_jugada), .valido(valido), .gano(gano), .random_valido(random_valido),
        .volver_inicio(volver_inicio), .jugador(c_jug), .en_turno(c_et), .en_verificar(c_ev),
        .en_random(c_er), .tiempo_restante(c_t), .fin_juego(c_fin), .ganador(c_gan), .empate(c_emp));

    always_comb begin
        act = '0;
        case (sel)
            0: act = {1'b0, a_jug, 2'b0, a_et, a_ev, a_er, a_t, a_fin, 1'b0, a_gan, a_emp};
            1: act = {b_jug, b_et, b_ev, b_er, b_t, b_fin, b_gan, b_emp};
            default: act = {c_jug, 1'b0, c_et, c_ev, c_er, 1'b0, c_t, c_fin, c_gan, c_emp};
        endcase
    end

    // game rules as read from the spec, one call per clock edge
    task automatic model_step(input in_t i);
        if (i.rst) begin
            ph = M_START; cur = 0; left = 0; miss = 0; placed = 0; win = 0; draw = 0;
            return;
        end
        case (ph)
            M_START: begin placed = 0; miss = 0; win = 0; draw = 0; ph = M_MENU; end
            M_MENU: if (i.ini) ph = M_PICK;
            M_PICK: begin cur = (int'(i.jini) < np) ? int'(i.jini) : 0; left = tc - 1; ph = M_TURN; end
            M_TURN: if (i.tj) ph = M_CHECK; else if (left == 0) ph = M_RAND; else left--;
            M_CHECK: if (i.val) ph = M_SCORE; else begin miss++; ph = (miss == mr) ? M_RAND : M_TURN; end
            M_RAND: if (i.rv) ph = M_SCORE;
            M_SCORE: begin
                placed++; miss = 0;
                if (i.gano) begin win = cur; ph = M_OVER; end
                else if (placed == bc) begin draw = 1; ph = M_OVER; end
                else begin cur = (cur + 1) % np; left = tc - 1; ph = M_TURN; end
            end
            M_OVER: if (i.volv) ph = M_START;
            default: ph = M_START;
        endcase
    endtask

    function automatic out_t model_out();
        out_t m;
        m.jug = 2'(cur);
        m.et = (ph == M_TURN) ? 4'(1 << cur) : 4'd0;
        m.ev = ph == M_CHECK;
        m.er = ph == M_RAND;
        m.t = 3'(left);
        m.fin = ph == M_OVER;
        m.gan = 2'(win);
        m.emp = draw;
        return m;
    endfunction

    task automatic chk(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    task automatic drive(input in_t i);
        rst = i.rst; inicio_juego = i.ini; jini = i.jini; t_jugada = i.tj; valido = i.val;
        gano = i.gano; random_valido = i.rv; volver_inicio = i.volv;
        @(posedge clk);
        model_step(i);
        #1;
    endtask

    task automatic cycm(input in_t i);
        drive(i);
        chk("model", act, model_out());
    endtask

    task automatic setcfg(input int s);
        sel = s;
        np = (s == 0) ? 2 : (s == 1) ? 4 : 3;
        tc = (s == 0) ? 8 : (s == 1) ? 6 : 4;
        mr = (s == 0) ? 3 : (s == 1) ? 2 : 1;
        bc = (s == 0) ? 4 : (s == 1) ? 10 : 42;
    endtask

    task automatic add(input in_t i, input int jug, et, ev, er, t, fin, gan, emp);
        row_t r;
        r.i = i;
        r.o = {2'(jug), 4'(et), 1'(ev), 1'(er), 3'(t), 1'(fin), 2'(gan), 1'(emp)};
        tab.push_back(r);
    endtask

    initial begin
        int n;
        int ord[5] = '{3, 0, 1, 2, 3};
        in_t r;
        // inputs, then jug et ev er t fin gan emp after the edge (dut_a: 2 players, 8 cycles, 3 retries, 4 cells)
        add(RST, 0, 0, 0, 0, 0, 0, 0, 0);  add(IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        add(INI, 0, 0, 0, 0, 0, 0, 0, 0);  add(J1, 1, 2, 0, 0, 7, 0, 0, 0);
        add(IDLE, 1, 2, 0, 0, 6, 0, 0, 0); add(TJ, 1, 0, 1, 0, 6, 0, 0, 0);
        add(VAL, 1, 0, 0, 0, 6, 0, 0, 0);  add(IDLE, 0, 1, 0, 0, 7, 0, 0, 0);
        add(TJ, 0, 0, 1, 0, 7, 0, 0, 0);   add(IDLE, 0, 1, 0, 0, 7, 0, 0, 0);
        add(IDLE, 0, 1, 0, 0, 6, 0, 0, 0); add(TJ, 0, 0, 1, 0, 6, 0, 0, 0);
        add(IDLE, 0, 1, 0, 0, 6, 0, 0, 0); add(TJ, 0, 0, 1, 0, 6, 0, 0, 0);
        add(IDLE, 0, 0, 0, 1, 6, 0, 0, 0); add(IDLE, 0, 0, 0, 1, 6, 0, 0, 0);
        add(RV, 0, 0, 0, 0, 6, 0, 0, 0);   add(IDLE, 1, 2, 0, 0, 7, 0, 0, 0);
        add(TJ, 1, 0, 1, 0, 7, 0, 0, 0);   add(VAL, 1, 0, 0, 0, 7, 0, 0, 0);
        add(IDLE, 0, 1, 0, 0, 7, 0, 0, 0); add(TJ, 0, 0, 1, 0, 7, 0, 0, 0);
        add(VAL, 0, 0, 0, 0, 7, 0, 0, 0);  add(IDLE, 0, 0, 0, 0, 7, 1, 0, 1);
        add(IDLE, 0, 0, 0, 0, 7, 1, 0, 1); add(VOLV, 0, 0, 0, 0, 7, 0, 0, 1);
        add(IDLE, 0, 0, 0, 0, 7, 0, 0, 0); add(INI, 0, 0, 0, 0, 7, 0, 0, 0);
        add(IDLE, 0, 1, 0, 0, 7, 0, 0, 0); add(TJ, 0, 0, 1, 0, 7, 0, 0, 0);
        add(VAL, 0, 0, 0, 0, 7, 0, 0, 0);  add(IDLE, 1, 2, 0, 0, 7, 0, 0, 0);
        add(TJ, 1, 0, 1, 0, 7, 0, 0, 0);   add(VAL, 1, 0, 0, 0, 7, 0, 0, 0);
        add(GANO, 1, 0, 0, 0, 7, 1, 1, 0);
        setcfg(0);
        foreach (tab[k]) begin
            drive(tab[k].i);
            chk($sformatf("vec%0d", k), act, tab[k].o);
        end

        // timeout length, then a move arriving on the last timer cycle
        cycm(RST); cycm(IDLE); cycm(INI); cycm(IDLE);
        n = 0;
        while (!act.er && n < 20) begin cycm(IDLE); n++; end
        chk_int("timeout_len", n, 8);
        cycm(RV); cycm(IDLE);
        chk_int("after_timeout_player", int'(act.jug), 1);
        for (int k = 0; k < 7; k++) cycm(IDLE);
        cycm(TJ);
        chk_int("tj_beats_timeout", {act.ev, act.er}, 2);

        // two misses then a valid move clear the retry count
        cycm(IDLE); cycm(TJ); cycm(IDLE); cycm(TJ); cycm(VAL); cycm(IDLE);
        cycm(TJ); cycm(IDLE); cycm(TJ); cycm(IDLE);
        chk_int("retry_cleared", int'(act.er), 0);
        cycm(TJ); cycm(IDLE);
        chk_int("third_retry_random", int'(act.er), 1);
        cycm(RST);
        chk("rst_in_random", act, '0);
        cycm(IDLE); cycm(INI); cycm(J1); cycm(TJ);
        cycm(RST);
        chk("rst_in_verificar", act, '0);

        setcfg(1);
        cycm(RST); cycm(IDLE); cycm(INI); cycm(J3);
        for (int k = 0; k < 5; k++) begin
            chk_int($sformatf("order%0d", k), int'(act.jug), ord[k]);
            cycm(TJ); cycm(VAL); cycm(IDLE);
        end

        setcfg(2);
        cycm(RST); cycm(IDLE); cycm(INI); cycm(J3);
        chk_int("clamp_jug", int'(act.jug), 0);
        chk_int("clamp_en_turno", int'(act.et), 1);

        for (int s = 0; s < 3; s++) begin
            setcfg(s);
            cycm(RST);
            for (int k = 0; k < 1500; k++) begin
                r.rst = $urandom_range(0, 299) == 0;
                r.ini = $urandom_range(0, 2) == 0;
                r.jini = (s == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
                r.tj = $urandom_range(0, 5) == 0;
                r.val = $urandom_range(0, 1) == 0;
                r.gano = $urandom_range(0, 9) == 0;
                r.rv = $urandom_range(0, 2) == 0;
                r.volv = $urandom_range(0, 3) == 0;
                cycm(r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
